clk_cfg_seq: RTL

CLK_CFG_SEQ -- requirements
Module: clk_cfg_seq

---
 rtl/clk_cfg_seq_pkg.sv | 31 +++
 rtl/clk_cfg_seq_sync2.sv | 22 ++
 rtl/clk_cfg_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/clk_cfg_seq_pkg.sv
// Shared definitions for the clock-configuration sequencer: FSM states,
// request bit-field positions and reset values of the clock-manager selects.
package clk_cfg_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PARK     = 3'd1,
    ST_CFG      = 3'd2,
    ST_UNPARK   = 3'd3,
    ST_FALLBACK = 3'd4
  } state_t;

  // req_cfg field positions
  localparam int CFG_MUX0     = 0;
  localparam int CFG_MUX1     = 1;
  localparam int CFG_MUX2     = 2;
  localparam int CFG_ROSC_LSB = 3;
  localparam int CFG_DIV_LSB  = 5;
  localparam int CFG_RSVD     = 7;

  // Reset values of the multi-bit selects
  localparam logic [1:0] ROSC_RST = 2'b11;
  localparam logic [1:0] DIV_RST  = 2'b00;

  // A request is refused if the reserved bit is set, or if it asks for the
  // external clock (mux1) while a failure is still latched.
  function automatic logic cfg_reject(input logic [7:0] cfg, input logic fail);
    return cfg[CFG_RSVD] | (cfg[CFG_MUX1] & fail);
  endfunction

endpackage

// File: rtl/clk_cfg_seq_sync2.sv
// Two-flop synchronizer bringing an asynchronous flag into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous input, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/clk_cfg_seq.sv
// Clock-configuration sequencer: parks the system clock on the ROSC, applies
// a requested mux/ROSC/divider configuration, then unparks. Falls back off
// the external clock when the clock monitor reports a failure.
module clk_cfg_seq
  import clk_cfg_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cfg,
  input  logic       xclk_fail,
  input  logic       fail_clr,
  output logic       sel_mux0,
  output logic       sel_mux1,
  output logic       sel_mux2,
  output logic [1:0] sel_rosc,
  output logic [1:0] clk_div,
  output logic       busy,
  output logic       done,
  output logic       req_err,
  output logic       fail_sticky
);

  // Counter loads with N-1 so a state lasts exactly N cycles
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [6:0] cfg_r;
  logic       xf_s;
  logic       accept_s;
  logic       fail_s;
  logic       reject_s;
  logic       clr_s;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (xclk_fail),
    .q   (xf_s)
  );

  // Handshake, failure and flag-clear qualifiers for the FSM
  always_comb begin
    accept_s = req_valid & req_ready;
    fail_s   = xf_s & sel_mux1;
    reject_s = cfg_reject(req_cfg, fail_sticky);
    clr_s    = fail_clr & (state_r == ST_IDLE) & ~xf_s;
  end

  // Sequencer FSM with settle counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      cfg_r       <= 7'd0;
      req_ready   <= 1'b0;
      sel_mux0    <= 1'b0;
      sel_mux1    <= 1'b0;
      sel_mux2    <= 1'b0;
      sel_rosc    <= ROSC_RST;
      clk_div     <= DIV_RST;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_err     <= 1'b0;
      fail_sticky <= 1'b0;
    end else begin
      done    <= 1'b0;
      req_err <= 1'b0;

      // A new failure wins over a clear in the same cycle
      if (fail_s) begin
        fail_sticky <= 1'b1;
      end else if (clr_s) begin
        fail_sticky <= 1'b0;
      end else begin
        fail_sticky <= fail_sticky;
      end

      if (fail_s) begin
        // Abort whatever is running and move off the external clock
        state_r   <= ST_FALLBACK;
        cnt_r     <= SETTLE_LOAD;
        sel_mux0  <= 1'b0;
        sel_mux1  <= 1'b0;
        busy      <= 1'b1;
        req_ready <= 1'b0;
        // A request handshaken in this same cycle cannot be executed
        req_err   <= accept_s;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (accept_s && !reject_s) begin
              cfg_r     <= req_cfg[6:0];
              state_r   <= ST_PARK;
              cnt_r     <= SETTLE_LOAD;
              sel_mux0  <= 1'b0;
              busy      <= 1'b1;
              req_ready <= 1'b0;
            end else begin
              req_err   <= accept_s;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end
          end
          ST_PARK: begin
            if (cnt_r == 8'd0) begin
              state_r  <= ST_CFG;
              cnt_r    <= SETTLE_LOAD;
              sel_mux1 <= cfg_r[CFG_MUX1];
              sel_mux2 <= cfg_r[CFG_MUX2];
              sel_rosc <= cfg_r[CFG_ROSC_LSB +: 2];
              clk_div  <= cfg_r[CFG_DIV_LSB +: 2];
            end else begin
              cnt_r <= cnt_r - 8'd1;
            end
          end
          ST_CFG: begin
            if (cnt_r == 8'd0) begin
              state_r  <= ST_UNPARK;
              cnt_r    <= SETTLE_LOAD;
              sel_mux0 <= cfg_r[CFG_MUX0];
            end else begin
              cnt_r <= cnt_r - 8'd1;
            end
          end
          ST_UNPARK: begin
            if (cnt_r == 8'd0) begin
              state_r   <= ST_IDLE;
              done      <= 1'b1;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              cnt_r <= cnt_r - 8'd1;
            end
          end
          ST_FALLBACK: begin
            if (cnt_r == 8'd0) begin
              state_r   <= ST_IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              cnt_r <= cnt_r - 8'd1;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
